p4_alu_arbiter: RTL and testbench

Round-robin scheduler that shares one registered XOR/OR datapath (3-bit A/B operands, Ora op select, Ad load control, registered C outputs) among N_REQ requesters. It latches the winning request, drives the datapath issue signals for one cycle, captures the registered result and returns it with a one-cycle Done pulse. It sits between the requesting blocks and the datapath instance, which is wired externally to the Dp_* ports.

---
 rtl/p4_alu_arbiter_if.sv | 29 ++
 rtl/p4_alu_arbiter.sv | 136 +++++++++++++
 tb/tb_p4_alu_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/p4_alu_arbiter_if.sv
// Bundle between requesters, the round-robin ALU arbiter and the shared XOR/OR datapath.
// The arbiter takes the slave view; requesters plus the datapath drive through master.
interface p4_alu_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 3
);
    logic [N_REQ-1:0]    Req;
    logic [N_REQ*DW-1:0] Req_A;
    logic [N_REQ*DW-1:0] Req_B;
    logic [N_REQ-1:0]    Req_Op;
    logic [N_REQ-1:0]    Done;
    logic [DW-1:0]       Rsp_Data;
    logic                Busy;
    logic [DW-1:0]       Dp_A;
    logic [DW-1:0]       Dp_B;
    logic                Dp_Ora;
    logic                Dp_Ad;
    logic [DW-1:0]       Dp_C;

    modport master (
        output Req, Req_A, Req_B, Req_Op, Dp_C,
        input  Done, Rsp_Data, Busy, Dp_A, Dp_B, Dp_Ora, Dp_Ad
    );

    modport slave (
        input  Req, Req_A, Req_B, Req_Op, Dp_C,
        output Done, Rsp_Data, Busy, Dp_A, Dp_B, Dp_Ora, Dp_Ad
    );
endinterface

// File: rtl/p4_alu_arbiter.sv
// Round-robin scheduler sharing one registered XOR/OR datapath among N_REQ requesters.
// Define P4_ARB_OPCNT_EN to add the saturating Op_Cnt completion counter port.
module p4_alu_arbiter #(
    parameter int N_REQ = 2,
    parameter int DW    = 3
) (
    input logic Clk,
    input logic Rst,
    p4_alu_arbiter_if.slave bus
`ifdef P4_ARB_OPCNT_EN
    ,
    output logic [7:0] Op_Cnt
`endif
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

    stateT            state, stateNext;
    logic [IW-1:0]    last, lastNext;
    logic [IW-1:0]    grant, grantNext;
    logic [N_REQ-1:0] done, doneNext;
    logic [DW-1:0]    rspData, rspNext;
    logic             busy, busyNext;
    logic [DW-1:0]    dpA, aNext;
    logic [DW-1:0]    dpB, bNext;
    logic             dpOra, oraNext;
    logic             dpAd, adNext;
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;

    // Dp_A/Dp_B/Dp_Ora double as the operand latch, so they are loaded at grant and held afterwards.
    always_comb begin
        stateNext = state;
        lastNext  = last;
        grantNext = grant;
        doneNext  = '0;
        rspNext   = rspData;
        busyNext  = busy;
        aNext     = dpA;
        bNext     = dpB;
        oraNext   = dpOra;
        adNext    = 1'b1;
        found     = 1'b0;
        pick      = '0;
        cand      = '0;

        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(last) + k) % N_REQ);
            if (!found && bus.Req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    grantNext = pick;
                    lastNext  = pick;
                    aNext     = bus.Req_A[pick*DW +: DW];
                    bNext     = bus.Req_B[pick*DW +: DW];
                    oraNext   = bus.Req_Op[pick];
                    adNext    = 1'b0;
                    busyNext  = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                stateNext = WAIT;
            end
            WAIT: begin
                rspNext         = bus.Dp_C;
                doneNext[grant] = 1'b1;
                stateNext       = RESP;
            end
            RESP: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            last    <= IW'(N_REQ - 1);
            grant   <= '0;
            done    <= '0;
            rspData <= '0;
            busy    <= 1'b0;
            dpA     <= '0;
            dpB     <= '0;
            dpOra   <= 1'b0;
            dpAd    <= 1'b1;
        end else begin
            state   <= stateNext;
            last    <= lastNext;
            grant   <= grantNext;
            done    <= doneNext;
            rspData <= rspNext;
            busy    <= busyNext;
            dpA     <= aNext;
            dpB     <= bNext;
            dpOra   <= oraNext;
            dpAd    <= adNext;
        end
    end

`ifdef P4_ARB_OPCNT_EN
    logic [7:0] opCnt;

    // Counts completions, sticking at 255 rather than wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            opCnt <= '0;
        end else if (state == RESP && opCnt != 8'hFF) begin
            opCnt <= opCnt + 8'd1;
        end
    end

    assign Op_Cnt = opCnt;
`endif

    assign bus.Done     = done;
    assign bus.Rsp_Data = rspData;
    assign bus.Busy     = busy;
    assign bus.Dp_A     = dpA;
    assign bus.Dp_B     = dpB;
    assign bus.Dp_Ora   = dpOra;
    assign bus.Dp_Ad    = dpAd;
endmodule

// File: tb/tb_p4_alu_arbiter.sv
// Bench for p4_alu_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_p4_alu_arbiter;
    localparam int N_REQ = 2;
    localparam int DW    = 3;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    p4_alu_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

`ifdef P4_ARB_OPCNT_EN
    logic [7:0] opCnt;
`endif

    p4_alu_arbiter #(.N_REQ(N_REQ), .DW(DW)) dut (
        .Clk(Clk),
        .Rst(Rst),
`ifdef P4_ARB_OPCNT_EN
        .Op_Cnt(opCnt),
`endif
        .bus(bus)
    );

    // Stand-in for the external datapath: loads the selected function when Dp_Ad is low.
    logic [DW-1:0] dpReg = '0;
    always @(posedge Clk) begin
        if (!bus.Dp_Ad) dpReg <= bus.Dp_Ora ? (bus.Dp_A | bus.Dp_B) : (bus.Dp_A ^ bus.Dp_B);
    end
    assign bus.Dp_C = dpReg;

    logic [N_REQ-1:0] reqV  = '0;
    logic [N_REQ-1:0] reqOp = '0;
    logic [DW-1:0]    opA [N_REQ];
    logic [DW-1:0]    opB [N_REQ];

    int cyc      = 0;
    int errors   = 0;
    int checks   = 0;
    int mLast    = N_REQ - 1;
    int mFree    = 0;
    int rstCycle = -1;
    int mCnt     = 0;
    bit gValid   = 1'b0;
    int gCycle   = 0;
    int gIdx     = 0;
    logic [DW-1:0] gA, gB, gData;
    logic gOp;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, expected);
        end
    endtask

    task automatic driveBus();
        for (int i = 0; i < N_REQ; i++) begin
            bus.Req_A[i*DW +: DW] = opA[i];
            bus.Req_B[i*DW +: DW] = opB[i];
        end
        bus.Req    = reqV;
        bus.Req_Op = reqOp;
    endtask

    // One op in flight at a time: a grant at cycle n means ISSUE at n+1, Done at n+3, IDLE again at n+4.
    task automatic stepCycle(input bit doRst);
        int  w;
        bit  hit;
        Rst = doRst;
        driveBus();
        if (doRst) begin
            gValid   = 1'b0;
            mLast    = N_REQ - 1;
            mFree    = cyc + 1;
            rstCycle = cyc + 1;
            mCnt     = 0;
        end else if (cyc >= mFree && reqV != '0) begin
            hit = 1'b0;
            w   = 0;
            for (int k = 1; k <= N_REQ; k++) begin
                if (!hit && reqV[(mLast + k) % N_REQ]) begin
                    hit = 1'b1;
                    w   = (mLast + k) % N_REQ;
                end
            end
            gValid = 1'b1;
            gCycle = cyc;
            gIdx   = w;
            gA     = opA[w];
            gB     = opB[w];
            gOp    = reqOp[w];
            gData  = gOp ? (gA | gB) : (gA ^ gB);
            mLast  = w;
            mFree  = cyc + 4;
        end
        @(posedge Clk);
        #1;
        cyc++;
        checkCycle();
    endtask

    task automatic checkCycle();
        logic [N_REQ-1:0] expDone;
        bit inOp, issue;
        inOp    = gValid && cyc > gCycle && cyc <= gCycle + 3;
        issue   = gValid && cyc == gCycle + 1;
        expDone = '0;
        if (gValid && cyc == gCycle + 3) expDone[gIdx] = 1'b1;

        checkOutput("done", 32'(bus.Done), 32'(expDone));
        checkOutput("busy", 32'(bus.Busy), 32'(inOp));
        checkOutput("dp_ad", 32'(bus.Dp_Ad), 32'(!issue));
        if (issue) begin
            checkOutput("dp_a", 32'(bus.Dp_A), 32'(gA));
            checkOutput("dp_b", 32'(bus.Dp_B), 32'(gB));
            checkOutput("dp_ora", 32'(bus.Dp_Ora), 32'(gOp));
        end
        if (expDone != '0) checkOutput("rsp_data", 32'(bus.Rsp_Data), 32'(gData));
        if (cyc == rstCycle) begin
            checkOutput("rst_dp_a", 32'(bus.Dp_A), 32'd0);
            checkOutput("rst_dp_b", 32'(bus.Dp_B), 32'd0);
            checkOutput("rst_dp_ora", 32'(bus.Dp_Ora), 32'd0);
            checkOutput("rst_rsp", 32'(bus.Rsp_Data), 32'd0);
        end
`ifdef P4_ARB_OPCNT_EN
        checkOutput("op_cnt", 32'(opCnt), 32'(mCnt));
        if (expDone != '0 && mCnt < 255) mCnt++;
`endif
    endtask

    task automatic randomizeReq(input int i);
        reqV[i]  = 1'b1;
        opA[i]   = DW'($urandom);
        opB[i]   = DW'($urandom);
        reqOp[i] = 1'($urandom);
    endtask

    // Requester behaviour: mode 0 holds everything, 1 drops on Done, 2 is random traffic.
    task automatic applyStimulus(input int mode);
        for (int i = 0; i < N_REQ; i++) begin
            if (mode != 0) begin
                if (bus.Done[i]) begin
                    if (mode == 1 || $urandom_range(1, 0) == 0) reqV[i] = 1'b0;
                    else randomizeReq(i);
                end else if (mode == 2) begin
                    if (gValid && i == gIdx && cyc > gCycle && cyc < gCycle + 3) begin
                        if ($urandom_range(3, 0) == 0) begin
                            opA[i]   = DW'($urandom);
                            opB[i]   = DW'($urandom);
                            reqOp[i] = 1'($urandom);
                        end else if ($urandom_range(7, 0) == 0) begin
                            reqV[i] = 1'b0;
                        end
                    end else if (!reqV[i] && $urandom_range(3, 0) == 0) begin
                        randomizeReq(i);
                    end
                end
            end
        end
    endtask

    task automatic runCycles(input int n, input int mode);
        repeat (n) begin
            stepCycle(1'b0);
            applyStimulus(mode);
        end
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        stepCycle(1'b1);
        stepCycle(1'b1);

        // XOR on requester 0: 101 ^ 011 = 110
        reqV     = 2'b01;
        opA[0]   = 3'b101;
        opB[0]   = 3'b011;
        reqOp[0] = 1'b0;
        runCycles(6, 1);

        // OR on requester 1: 100 | 001 = 101
        reqV     = 2'b10;
        opA[1]   = 3'b100;
        opB[1]   = 3'b001;
        reqOp[1] = 1'b1;
        runCycles(6, 1);

        // Both held from reset: strict alternation, long enough to saturate the counter
        stepCycle(1'b1);
        reqV   = 2'b11;
        opA[0] = 3'b110; opB[0] = 3'b011; reqOp[0] = 1'b0;
        opA[1] = 3'b010; opB[1] = 3'b100; reqOp[1] = 1'b1;
        runCycles(1210, 0);
        reqV = 2'b00;
        runCycles(5, 0);

        // Reset during WAIT abandons the op; requester 0 wins first afterwards
        stepCycle(1'b1);
        reqV   = 2'b01;
        opA[0] = 3'b111; opB[0] = 3'b001; reqOp[0] = 1'b0;
        stepCycle(1'b0);
        stepCycle(1'b0);
        stepCycle(1'b1);
        reqV = 2'b11;
        runCycles(10, 1);
        reqV = 2'b00;
        runCycles(4, 1);

        // Operands change right after grant; result must use the latched ones
        reqV     = 2'b01;
        opA[0]   = 3'b011;
        opB[0]   = 3'b101;
        reqOp[0] = 1'b1;
        stepCycle(1'b0);
        opA[0]   = 3'b000;
        opB[0]   = 3'b000;
        reqOp[0] = 1'b0;
        runCycles(5, 1);

        repeat (3000) begin
            stepCycle($urandom_range(79, 0) == 0);
            applyStimulus(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
